// File: rtl/rvfi_commit_buffer_if.sv
// Commit-side and consumer-side signals of rvfi_commit_buffer.
// Defining RVFI_CYCLE_STAMP_EN adds the out_cycle stamp.
interface rvfi_commit_buffer_if #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ORDER_W  = 64
);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic [CHANNELS-1:0]      in_valid;
   logic [CHANNELS*XLEN-1:0] in_pc_rdata;
   logic [CHANNELS*XLEN-1:0] in_pc_wdata;
   logic [CHANNELS*32-1:0]   in_inst;
   logic [CHANNELS-1:0]      in_trap;

   logic                     out_valid;
   logic                     out_ready;
   logic [ORDER_W-1:0]       out_order;
   logic [XLEN-1:0]          out_pc_rdata;
   logic [XLEN-1:0]          out_pc_wdata;
   logic [31:0]              out_inst;
   logic                     out_trap;

   logic [CntW-1:0]          count;
   logic                     halt;
   logic                     overflow;
   logic                     trap_seen;
`ifdef RVFI_CYCLE_STAMP_EN
   logic [ORDER_W-1:0]       out_cycle;
`endif

   modport master (
`ifdef RVFI_CYCLE_STAMP_EN
      input  out_cycle,
`endif
      output in_valid, in_pc_rdata, in_pc_wdata, in_inst, in_trap, out_ready,
      input  out_valid, out_order, out_pc_rdata, out_pc_wdata, out_inst, out_trap,
      input  count, halt, overflow, trap_seen
   );

   modport slave (
`ifdef RVFI_CYCLE_STAMP_EN
      output out_cycle,
`endif
      input  in_valid, in_pc_rdata, in_pc_wdata, in_inst, in_trap, out_ready,
      output out_valid, out_order, out_pc_rdata, out_pc_wdata, out_inst, out_trap,
      output count, halt, overflow, trap_seen
   );
endinterface

// File: rtl/rvfi_commit_buffer.sv
// Multi-channel RVFI commit buffer: orders up to CHANNELS retirements per cycle, detects the
// jump-to-self halt idiom and serialises records through a FIFO. Option: RVFI_CYCLE_STAMP_EN.
module rvfi_commit_buffer #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ORDER_W  = 64
) (
   input logic                 clk,
   input logic                 rst,
   rvfi_commit_buffer_if.slave bus
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [0:0] {StRun, StHalted} state_e;

   state_e             state_q, state_d;
   logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]    count_q, count_d;
   logic [ORDER_W-1:0] order_q, order_d;
   logic               overflow_q, overflow_d;
   logic               trap_seen_q, trap_seen_d;

   logic [ORDER_W-1:0] mem_order [DEPTH];
   logic [XLEN-1:0]    mem_pc_r  [DEPTH];
   logic [XLEN-1:0]    mem_pc_w  [DEPTH];
   logic [31:0]        mem_inst  [DEPTH];
   logic               mem_trap  [DEPTH];

   logic [CHANNELS-1:0] wr_en;
   logic [PtrW-1:0]     wr_addr  [CHANNELS];
   logic [ORDER_W-1:0]  wr_order [CHANNELS];
   logic [CntW-1:0]     free;
   logic [CntW-1:0]     n_push;
   logic [ORDER_W-1:0]  n_seen;
   logic                stop;
   logic                pop;

   always_comb begin
      state_d     = state_q;
      overflow_d  = overflow_q;
      trap_seen_d = trap_seen_q;
      wr_en       = '0;
      free        = CntW'(DEPTH) - count_q;
      n_push      = '0;
      n_seen      = '0;
      stop        = (state_q != StRun);
      for (int i = 0; i < CHANNELS; i++) begin
         wr_addr[i]  = wr_ptr_q + n_push[PtrW-1:0];
         wr_order[i] = order_q + n_seen;
         if (bus.in_valid[i] && !stop) begin
            // Order advances for every accepted-or-dropped channel so drops leave visible gaps.
            n_seen = n_seen + ORDER_W'(1);
            if (n_push < free) begin
               wr_en[i] = 1'b1;
               n_push   = n_push + CntW'(1);
               if (bus.in_trap[i]) trap_seen_d = 1'b1;
            end else begin
               overflow_d = 1'b1;
            end
            if ((bus.in_pc_rdata[i*XLEN +: XLEN] == bus.in_pc_wdata[i*XLEN +: XLEN]) &&
                !bus.in_trap[i]) begin
               stop    = 1'b1;
               state_d = StHalted;
            end
         end
      end
      pop      = (count_q != '0) && bus.out_ready;
      order_d  = order_q + n_seen;
      wr_ptr_d = wr_ptr_q + n_push[PtrW-1:0];
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      count_d  = count_q + n_push - CntW'(pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StRun;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         order_q     <= '0;
         overflow_q  <= 1'b0;
         trap_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         order_q     <= order_d;
         overflow_q  <= overflow_d;
         trap_seen_q <= trap_seen_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (wr_en[i]) begin
            mem_order[wr_addr[i]] <= wr_order[i];
            mem_pc_r[wr_addr[i]]  <= bus.in_pc_rdata[i*XLEN +: XLEN];
            mem_pc_w[wr_addr[i]]  <= bus.in_pc_wdata[i*XLEN +: XLEN];
            mem_inst[wr_addr[i]]  <= bus.in_inst[i*32 +: 32];
            mem_trap[wr_addr[i]]  <= bus.in_trap[i];
         end
      end
   end

`ifdef RVFI_CYCLE_STAMP_EN
   logic [ORDER_W-1:0] cycle_q, cycle_d;
   logic [ORDER_W-1:0] mem_cycle [DEPTH];

   always_comb begin
      cycle_d = (state_q == StRun) ? cycle_q + ORDER_W'(1) : cycle_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (wr_en[i]) mem_cycle[wr_addr[i]] <= cycle_q;
      end
   end

   assign bus.out_cycle = mem_cycle[rd_ptr_q];
`endif

   assign bus.out_valid    = (count_q != '0);
   assign bus.out_order    = mem_order[rd_ptr_q];
   assign bus.out_pc_rdata = mem_pc_r[rd_ptr_q];
   assign bus.out_pc_wdata = mem_pc_w[rd_ptr_q];
   assign bus.out_inst     = mem_inst[rd_ptr_q];
   assign bus.out_trap     = mem_trap[rd_ptr_q];
   assign bus.count        = count_q;
   assign bus.halt         = (state_q == StHalted);
   assign bus.overflow     = overflow_q;
   assign bus.trap_seen    = trap_seen_q;
endmodule

// File: tb/tb_rvfi_commit_buffer.sv
// Bench for rvfi_commit_buffer: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_rvfi_commit_buffer;
   localparam int unsigned CH    = 2;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned OW    = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rvfi_commit_buffer_if #(.CHANNELS(CH), .DEPTH(DEPTH), .XLEN(XLEN), .ORDER_W(OW)) bus ();

   rvfi_commit_buffer #(.CHANNELS(CH), .DEPTH(DEPTH), .XLEN(XLEN), .ORDER_W(OW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_ch(input int i, input logic v, input logic [31:0] pcr,
                         input logic [31:0] pcw, input logic [31:0] inst, input logic trap);
      bus.in_valid[i]                  = v;
      bus.in_pc_rdata[i*XLEN +: XLEN] = pcr;
      bus.in_pc_wdata[i*XLEN +: XLEN] = pcw;
      bus.in_inst[i*32 +: 32]         = inst;
      bus.in_trap[i]                   = trap;
   endtask

   task automatic idle();
      bus.in_valid = '0;
      bus.in_trap  = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle();
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Reference model: a queue of records plus sticky flags.
   typedef struct {
      logic [63:0] order;
      logic [31:0] pcr;
      logic [31:0] pcw;
      logic [31:0] inst;
      logic        trap;
   } rec_t;

   rec_t        mq[$];
   logic [63:0] m_order;
   bit          m_halt, m_ovf, m_ts;

   function automatic void model_reset();
      mq.delete();
      m_order = '0;
      m_halt  = 1'b0;
      m_ovf   = 1'b0;
      m_ts    = 1'b0;
   endfunction

   function automatic void model_edge();
      int   room;
      bit   do_pop;
      rec_t acc[$];
      rec_t r;
      room   = int'(DEPTH) - mq.size();
      do_pop = (mq.size() > 0) && (bus.out_ready == 1'b1);
      if (!m_halt) begin
         for (int i = 0; i < CH; i++) begin
            if (!bus.in_valid[i]) continue;
            r.order = m_order;
            r.pcr   = bus.in_pc_rdata[i*XLEN +: XLEN];
            r.pcw   = bus.in_pc_wdata[i*XLEN +: XLEN];
            r.inst  = bus.in_inst[i*32 +: 32];
            r.trap  = bus.in_trap[i];
            m_order = m_order + 64'd1;
            if (acc.size() < room) begin
               acc.push_back(r);
               if (r.trap) m_ts = 1'b1;
            end else begin
               m_ovf = 1'b1;
            end
            if (r.pcr == r.pcw && !r.trap) begin
               m_halt = 1'b1;
               break;
            end
         end
      end
      if (do_pop) void'(mq.pop_front());
      foreach (acc[k]) mq.push_back(acc[k]);
   endfunction

   task automatic compare_model(input int c);
      chk($sformatf("rnd%0d.out_valid", c), bus.out_valid, mq.size() != 0);
      chk($sformatf("rnd%0d.count", c), bus.count, mq.size());
      chk($sformatf("rnd%0d.halt", c), bus.halt, m_halt);
      chk($sformatf("rnd%0d.overflow", c), bus.overflow, m_ovf);
      chk($sformatf("rnd%0d.trap_seen", c), bus.trap_seen, m_ts);
      if (mq.size() > 0) begin
         chk($sformatf("rnd%0d.order", c), bus.out_order, mq[0].order);
         chk($sformatf("rnd%0d.pc_rdata", c), bus.out_pc_rdata, mq[0].pcr);
         chk($sformatf("rnd%0d.pc_wdata", c), bus.out_pc_wdata, mq[0].pcw);
         chk($sformatf("rnd%0d.inst", c), bus.out_inst, mq[0].inst);
         chk($sformatf("rnd%0d.trap", c), bus.out_trap, mq[0].trap);
      end
   endtask

   typedef struct {
      bit          do_rst;
      logic [1:0]  valid;
      logic [31:0] pcr0, pcw0, pcr1, pcw1;
      logic [1:0]  trap;
      logic        ready;
      logic        exp_valid;
      logic [4:0]  exp_count;
      logic [63:0] exp_order;
      logic [31:0] exp_pc;
      logic        exp_trap, exp_halt, exp_ts;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b0, 2'b11, 32'h60, 32'h64, 32'h64, 32'h68, 2'b00, 1'b1,
                  1'b1, 5'd2, 64'd0, 32'h60, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b1,
                  1'b1, 5'd1, 64'd1, 32'h64, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b1,
                  1'b0, 5'd0, 64'd0, 32'h0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 2'b10, 32'h0, 32'h0, 32'h100, 32'h104, 2'b00, 1'b1,
                  1'b1, 5'd1, 64'd0, 32'h100, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 2'b11, 32'h104, 32'h108, 32'h108, 32'h10c, 2'b00, 1'b1,
                  1'b1, 5'd2, 64'd1, 32'h104, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b1,
                  1'b1, 5'd1, 64'd2, 32'h108, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b1,
                  1'b0, 5'd0, 64'd0, 32'h0, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 2'b01, 32'h40, 32'h40, 32'h0, 32'h0, 2'b01, 1'b1,
                  1'b1, 5'd1, 64'd3, 32'h40, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b1,
                  1'b0, 5'd0, 64'd0, 32'h0, 1'b0, 1'b0, 1'b1};

      // Reset values while held in reset.
      rst = 1'b0;
      bus.out_ready   = 1'b0;
      bus.in_pc_rdata = '0;
      bus.in_pc_wdata = '0;
      bus.in_inst     = '0;
      idle();
      #12;
      chk("rst.out_valid", bus.out_valid, 1'b0);
      chk("rst.count", bus.count, 0);
      chk("rst.halt", bus.halt, 1'b0);
      chk("rst.overflow", bus.overflow, 1'b0);
      chk("rst.trap_seen", bus.trap_seen, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Directed vector table: dual push, channel-1-only push, trapped jump-to-self.
      for (int v = 0; v < 9; v++) begin
         if (vecs[v].do_rst) do_reset();
         set_ch(0, vecs[v].valid[0], vecs[v].pcr0, vecs[v].pcw0, 32'h13, vecs[v].trap[0]);
         set_ch(1, vecs[v].valid[1], vecs[v].pcr1, vecs[v].pcw1, 32'h13, vecs[v].trap[1]);
         bus.out_ready = vecs[v].ready;
         tick();
         chk($sformatf("vec%0d.out_valid", v), bus.out_valid, vecs[v].exp_valid);
         chk($sformatf("vec%0d.count", v), bus.count, vecs[v].exp_count);
         chk($sformatf("vec%0d.halt", v), bus.halt, vecs[v].exp_halt);
         chk($sformatf("vec%0d.trap_seen", v), bus.trap_seen, vecs[v].exp_ts);
         if (vecs[v].exp_valid) begin
            chk($sformatf("vec%0d.order", v), bus.out_order, vecs[v].exp_order);
            chk($sformatf("vec%0d.pc", v), bus.out_pc_rdata, vecs[v].exp_pc);
            chk($sformatf("vec%0d.trap", v), bus.out_trap, vecs[v].exp_trap);
         end
      end
      idle();

      // Overflow: fill to DEPTH-1, then a pair where only channel 0 fits.
      do_reset();
      for (int j = 0; j < 15; j++) begin
         set_ch(0, 1'b1, 32'h1000 + 32'(j * 8), 32'h1004 + 32'(j * 8), 32'h13, 1'b0);
         set_ch(1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
         tick();
      end
      chk("ovf.count15", bus.count, 15);
      chk("ovf.flag_clear", bus.overflow, 1'b0);
      set_ch(0, 1'b1, 32'h2000, 32'h2004, 32'h13, 1'b0);
      set_ch(1, 1'b1, 32'h2004, 32'h2008, 32'h13, 1'b0);
      tick();
      chk("ovf.count16", bus.count, 16);
      chk("ovf.flag_set", bus.overflow, 1'b1);
      idle();
      bus.out_ready = 1'b1;
      for (int j = 0; j < 16; j++) begin
         chk($sformatf("ovf.drain_order%0d", j), bus.out_order, 64'(j));
         chk($sformatf("ovf.drain_valid%0d", j), bus.out_valid, 1'b1);
         tick();
      end
      chk("ovf.drained_count", bus.count, 0);
      bus.out_ready = 1'b0;
      set_ch(0, 1'b1, 32'h3000, 32'h3004, 32'h13, 1'b0);
      tick();
      chk("ovf.next_order", bus.out_order, 64'd17);
      idle();

      // Halt idiom on channel 0 discards channel 1 and freezes pushes.
      do_reset();
      chk("halt.ovf_reset", bus.overflow, 1'b0);
      set_ch(0, 1'b1, 32'h200, 32'h204, 32'h13, 1'b0);
      set_ch(1, 1'b1, 32'h204, 32'h208, 32'h13, 1'b0);
      tick();
      set_ch(0, 1'b1, 32'h80, 32'h80, 32'h13, 1'b0);
      set_ch(1, 1'b1, 32'h84, 32'h88, 32'h13, 1'b0);
      tick();
      chk("halt.count", bus.count, 3);
      chk("halt.flag", bus.halt, 1'b1);
      chk("halt.no_ovf", bus.overflow, 1'b0);
      set_ch(0, 1'b1, 32'h90, 32'h94, 32'h13, 1'b0);
      set_ch(1, 1'b1, 32'h94, 32'h98, 32'h13, 1'b0);
      tick();
      chk("halt.ignored", bus.count, 3);
      idle();
      bus.out_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("halt.drain_order%0d", j), bus.out_order, 64'(j));
         tick();
      end
      chk("halt.drained", bus.out_valid, 1'b0);
      chk("halt.sticky", bus.halt, 1'b1);

      // Asynchronous reset mid-cycle with entries queued and halt set.
      do_reset();
      for (int j = 0; j < 5; j++) begin
         set_ch(0, 1'b1, 32'h300 + 32'(j * 8), (j == 4) ? 32'h300 + 32'(j * 8)
                                                       : 32'h304 + 32'(j * 8), 32'h13, 1'b0);
         set_ch(1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
         tick();
      end
      idle();
      chk("arst.pre_count", bus.count, 5);
      chk("arst.pre_halt", bus.halt, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst.out_valid", bus.out_valid, 1'b0);
      chk("arst.count", bus.count, 0);
      chk("arst.halt", bus.halt, 1'b0);
      chk("arst.overflow", bus.overflow, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      set_ch(0, 1'b1, 32'h400, 32'h404, 32'h13, 1'b0);
      tick();
      chk("arst.first_order", bus.out_order, 64'd0);
      chk("arst.first_count", bus.count, 1);
      idle();

      // Randomized traffic against the reference model.
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 249) begin
            do_reset();
            model_reset();
         end
         for (int i = 0; i < CH; i++) begin
            logic [31:0] pcr, pcw;
            pcr = $urandom & 32'hffff_fffc;
            pcw = ($urandom_range(0, 299) == 0) ? pcr : pcr + 32'd4;
            set_ch(i, ($urandom_range(0, 9) < 6), pcr, pcw, $urandom,
                   ($urandom_range(0, 7) == 0));
         end
         bus.out_ready = ((c / 40) % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         model_edge();
         tick();
         compare_model(c);
      end
      idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
